jtcop_sndlatch_tx: RTL and testbench

//  Main-CPU side of the sound command path. Buffers bytes written by the main
//  CPU in a small FIFO and presents them one at a time on latch/snreq to the

---
 rtl/jtcop_sndlatch_tx_if.sv | 27 ++
 rtl/jtcop_sndlatch_tx.sv | 160 ++++++++++++++++
 tb/tb_jtcop_sndlatch_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtcop_sndlatch_tx_if.sv
// Sound command bus between the main CPU decoder and the latch transmitter.
// master drives writes and acks, slave is the transmitter.
interface jtcop_sndlatch_tx_if #(
   parameter int AW = 2
);
   logic          main_we;
   logic [7:0]    main_din;
   logic          snd_ack;
   logic          ovf_clr;
   logic [7:0]    latch;
   logic          snreq;
   logic          busy;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic          ovf;

   modport master (
      output main_we, main_din, snd_ack, ovf_clr,
      input  latch, snreq, busy, full, empty, level, ovf
   );

   modport slave (
      input  main_we, main_din, snd_ack, ovf_clr,
      output latch, snreq, busy, full, empty, level, ovf
   );
endinterface

// File: rtl/jtcop_sndlatch_tx.sv
// Main-CPU side sound latch: FIFO of command bytes offered one at a time
// on latch/snreq, waiting for the sound CPU read and retrying on timeout.
module jtcop_sndlatch_tx #(
   parameter int AW      = 2,
   parameter int REQ_LEN = 4,
   parameter int TW      = 16
)(
   input  logic clk,
   input  logic rst_n,
   jtcop_sndlatch_tx_if.slave bus
);

   localparam int DEPTH = 2**AW;
   localparam int CW    = $clog2(REQ_LEN+1);
   localparam logic [TW-1:0] TMAX   = {TW{1'b1}};
   localparam logic [CW-1:0] CNT_END = CW'(REQ_LEN-1);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_GAP,
      S_WAIT
   } state_t;

   logic [7:0]    ram [DEPTH];
   logic [AW:0]   wptr, rptr;
   logic [AW:0]   wptr_nx, rptr_nx;
   logic [AW:0]   level_q, level_nx;
   logic          full_q, empty_q, ovf_q;
   logic          push, pop, drop;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [TW-1:0] tout, tout_nx;
   logic          ack_seen, ack_seen_nx;
   logic          snreq_q, snreq_nx;
   logic          busy_q, busy_nx;
   logic [7:0]    latch_q, latch_nx;

   // A full FIFO still accepts a write when the head leaves the same cycle
   assign pop  = (state == S_IDLE) && !empty_q;
   assign push = bus.main_we && (!full_q || pop);
   assign drop = bus.main_we && full_q && !pop;

   assign wptr_nx  = push ? wptr + 1'b1 : wptr;
   assign rptr_nx  = pop  ? rptr + 1'b1 : rptr;
   assign level_nx = wptr_nx - rptr_nx;

   // FIFO storage, deliberately not reset
   always_ff @(posedge clk) begin
      if (push) ram[wptr[AW-1:0]] <= bus.main_din;
   end

   // Pointers and registered occupancy flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr    <= wptr_nx;
         rptr    <= rptr_nx;
         level_q <= level_nx;
         full_q  <= (level_nx == FULL_LVL);
         empty_q <= (level_nx == '0);
      end
   end

   // Sticky overflow; a dropped write beats a clear in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           ovf_q <= 1'b0;
      else if (drop)        ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
   end

   // Handshake state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         tout     <= '0;
         ack_seen <= 1'b0;
         snreq_q  <= 1'b0;
         busy_q   <= 1'b0;
         latch_q  <= 8'h00;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         tout     <= tout_nx;
         ack_seen <= ack_seen_nx;
         snreq_q  <= snreq_nx;
         busy_q   <= busy_nx;
         latch_q  <= latch_nx;
      end
   end

   // Next-state: offer head, hold snreq, wait for ack, retry after timeout
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      tout_nx     = tout;
      ack_seen_nx = ack_seen;
      snreq_nx    = snreq_q;
      busy_nx     = busy_q;
      latch_nx    = latch_q;
      unique case (state)
         S_IDLE: begin
            if (!empty_q) begin
               latch_nx    = ram[rptr[AW-1:0]];
               snreq_nx    = 1'b1;
               busy_nx     = 1'b1;
               cnt_nx      = '0;
               tout_nx     = '0;
               ack_seen_nx = 1'b0;
               state_nx    = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.snd_ack) ack_seen_nx = 1'b1;
            if (cnt == CNT_END) begin
               snreq_nx = 1'b0;
               tout_nx  = '0;
               state_nx = S_WAIT;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.snd_ack || ack_seen) begin
               busy_nx     = 1'b0;
               ack_seen_nx = 1'b0;
               state_nx    = S_IDLE;
            end else begin
               tout_nx = tout + 1'b1;
               if (tout_nx == TMAX) state_nx = S_GAP;
            end
         end
         S_GAP: begin
            if (bus.snd_ack) ack_seen_nx = 1'b1;
            snreq_nx = 1'b1;
            cnt_nx   = '0;
            tout_nx  = '0;
            state_nx = S_REQ;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.latch = latch_q;
   assign bus.snreq = snreq_q;
   assign bus.busy  = busy_q;
   assign bus.full  = full_q;
   assign bus.empty = empty_q;
   assign bus.level = level_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_jtcop_sndlatch_tx.sv
// Bench for jtcop_sndlatch_tx: directed scenarios then random traffic,
// checked every cycle against a queue-and-timeline model.
module tb_jtcop_sndlatch_tx;

   localparam int AW      = 2;
   localparam int REQ_LEN = 4;
   localparam int TW      = 4;
   localparam int DEPTH   = 2**AW;
   localparam int WLEN    = 2**TW - 1;
   localparam int PER     = REQ_LEN + WLEN + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   jtcop_sndlatch_tx_if #(.AW(AW)) bus();

   jtcop_sndlatch_tx #(
      .AW(AW), .REQ_LEN(REQ_LEN), .TW(TW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: queued bytes, offered byte and time since its request began
   logic [7:0] q[$];
   logic       m_busy  = 1'b0;
   logic [7:0] m_latch = 8'h00;
   int         m_t     = 0;
   logic       m_acked = 1'b0;
   logic       m_ovf   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic m_snreq();
      return m_busy && ((m_t % PER) < REQ_LEN);
   endfunction

   task automatic model_clear();
      q.delete();
      m_busy  = 1'b0;
      m_latch = 8'h00;
      m_t     = 0;
      m_acked = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_edge(input logic we, input logic [7:0] din,
                             input logic ack, input logic clr);
      int   p;
      int   sz;
      logic pop;
      pop = !m_busy && (q.size() != 0);
      sz  = q.size();
      if (m_busy) begin
         p = m_t % PER;
         if (p >= REQ_LEN && p < REQ_LEN + WLEN && (ack || m_acked)) begin
            m_busy = 1'b0;
         end else begin
            if (ack) m_acked = 1'b1;
            m_t++;
         end
      end
      if (we && (sz < DEPTH || pop)) q.push_back(din);
      if (we && sz == DEPTH && !pop) m_ovf = 1'b1;
      else if (clr)                  m_ovf = 1'b0;
      if (pop) begin
         m_latch = q.pop_front();
         m_busy  = 1'b1;
         m_t     = 0;
         m_acked = 1'b0;
      end
   endtask

   task automatic compare_all();
      check("latch", 32'(bus.latch), 32'(m_latch));
      check("snreq", 32'(bus.snreq), 32'(m_snreq()));
      check("busy",  32'(bus.busy),  32'(m_busy));
      check("level", 32'(bus.level), q.size());
      check("full",  32'(bus.full),  32'(q.size() == DEPTH));
      check("empty", 32'(bus.empty), 32'(q.size() == 0));
      check("ovf",   32'(bus.ovf),   32'(m_ovf));
   endtask

   task automatic step(input logic we, input logic [7:0] din,
                       input logic ack, input logic clr);
      @(negedge clk);
      bus.main_we  = we;
      bus.main_din = din;
      bus.snd_ack  = ack;
      bus.ovf_clr  = clr;
      @(posedge clk);
      model_edge(we, din, ack, clr);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Reset asserted between edges; outputs must clear immediately
   task automatic do_reset();
      @(posedge clk);
      #3;
      bus.main_we = 1'b0;
      bus.snd_ack = 1'b0;
      bus.ovf_clr = 1'b0;
      rst_n = 1'b0;
      #1;
      model_clear();
      check("rst_snreq", 32'(bus.snreq), 0);
      check("rst_level", 32'(bus.level), 0);
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_busy",  32'(bus.busy),  0);
      check("rst_latch", 32'(bus.latch), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic ack_at(input int ph);
      return m_busy && ((m_t % PER) == ph);
   endfunction

   int   hi;
   int   edges;
   logic prev;
   logic ack;

   initial begin
      bus.main_we  = 1'b0;
      bus.main_din = 8'h00;
      bus.snd_ack  = 1'b0;
      bus.ovf_clr  = 1'b0;
      #12;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Single byte, pulse length, then a timeout retry and late ack
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("t1_latch", 32'(bus.latch), 32'h5A);
      check("t1_snreq", 32'(bus.snreq), 1);
      check("t1_level", 32'(bus.level), 0);
      hi = 1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0);
         if (bus.snreq) hi++;
      end
      check("t1_hi_len", hi, REQ_LEN);
      idle(PER + 3);
      check("t4_retry_latch", 32'(bus.latch), 32'h5A);
      while (!ack_at(REQ_LEN + 2)) step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("t4_busy", 32'(bus.busy), 0);

      // Three bytes back to back, each acked 10 cycles after snreq falls
      do_reset();
      edges = 0;
      prev  = 1'b0;
      for (int i = 0; i < 90; i++) begin
         ack = ack_at(REQ_LEN + 9);
         if (i < 3) step(1'b1, 8'(8'h11 * (i + 1)), ack, 1'b0);
         else       step(1'b0, 8'h00, ack, 1'b0);
         if (bus.snreq && !prev) edges++;
         prev = bus.snreq;
      end
      check("t2_edges", edges, 3);
      check("t2_latch", 32'(bus.latch), 32'h33);
      check("t2_empty", 32'(bus.empty), 1);

      // Overflow while busy, then clear
      do_reset();
      step(1'b1, 8'hA0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      check("t3_full",  32'(bus.full),  1);
      check("t3_level", 32'(bus.level), 4);
      check("t3_ovf",   32'(bus.ovf),   1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("t3_ovf_clr", 32'(bus.ovf), 0);
      for (int i = 0; i < 6 * PER; i++) begin
         step(1'b0, 8'h00, ack_at(REQ_LEN), 1'b0);
      end
      check("t3_last", 32'(bus.latch), 32'hA4);

      // Ack during the second REQ cycle ends the wait at once
      do_reset();
      step(1'b1, 8'hC3, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      idle(REQ_LEN);
      check("t5_busy", 32'(bus.busy), 0);
      idle(WLEN + 4);

      // Reset during REQ with two bytes queued
      step(1'b1, 8'h01, 1'b0, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0);
      check("t6_pre_level", 32'(bus.level), 2);
      check("t6_pre_snreq", 32'(bus.snreq), 1);
      do_reset();

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 1499) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 9) < 3, 8'($urandom),
                 m_busy ? ($urandom_range(0, 7) == 0)
                        : ($urandom_range(0, 49) == 0),
                 $urandom_range(0, 39) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
